piano_voice_allocator: RTL

Polyphonic voice controller between the 16-key matrix input and the tone-generator bank of `piano_system`. It synchronises and debounces the raw key lines and scans them round-robin. Each newly pressed key is assigned one of `NUM_VOICES` tone generators; when all voices are busy, the oldest allocation is stolen. Outputs are per-voice gate and key-index buses plus a one-cycle event strobe, consumed by the audio mixer and the VGA key-highlight logic.

---
 rtl/piano_pkg.sv | 20 ++
 rtl/key_debouncer.sv | 55 +++++
 rtl/piano_voice_allocator.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared sizing and event encodings for the piano voice path.
package piano_pkg;

  localparam int NUM_KEYS   = 16;
  localparam int KEY_W      = $clog2(NUM_KEYS);
  localparam int NUM_VOICES = 4;
  localparam int VOICE_W    = $clog2(NUM_VOICES);

  // Event kind carried on evt_on
  localparam logic EVT_OFF = 1'b0;
  localparam logic EVT_ON  = 1'b1;

  // Action decided for the key under the scan pointer
  typedef enum logic [1:0] {
    ACT_IDLE = 2'd0,
    ACT_ON   = 2'd1,
    ACT_OFF  = 2'd2
  } scan_act_e;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus tick-based two-sample debounce for a key bus.
module key_debouncer
  import piano_pkg::*;
#(
  parameter int WIDTH           = NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] keys,
  output logic [WIDTH-1:0] key_deb
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] prev_p2;
  logic [WIDTH-1:0] stable;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  // The tick fires in the cycle the counter wraps back to zero
  assign tick   = (tick_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign stable = ~(sync_p1 ^ prev_p2);

  // Stage p0/p1: metastability synchroniser on the raw key levels
  always_ff @(posedge clk) begin
    sync_p0 <= keys;
    sync_p1 <= sync_p0;
  end

  // Free-running sample-interval counter
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Stage p2: accept a sample only when it matches the previous tick's sample
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_p2 <= '0;
      key_deb <= '0;
    end else if (tick) begin
      prev_p2 <= sync_p1;
      key_deb <= (stable & sync_p1) | (~stable & key_deb);
    end
  end

endmodule

// File: rtl/piano_voice_allocator.sv
// Round-robin key scanner that assigns debounced key presses to tone
// generators, stealing the oldest allocation when every voice is busy.
module piano_voice_allocator
  import piano_pkg::*;
#(
  parameter int NUM_KEYS        = piano_pkg::NUM_KEYS,
  parameter int NUM_VOICES      = piano_pkg::NUM_VOICES,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  localparam int KEY_W          = $clog2(NUM_KEYS),
  localparam int VOICE_W        = $clog2(NUM_VOICES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_KEYS-1:0]         keys,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic                        evt_valid,
  output logic                        evt_on,
  output logic [VOICE_W-1:0]          evt_voice,
  output logic [KEY_W-1:0]            evt_key,
  output logic [NUM_KEYS-1:0]         key_deb
);

  logic [KEY_W-1:0]    idx;
  logic [NUM_KEYS-1:0] served;
  logic [KEY_W-1:0]    vkey [NUM_VOICES];
  logic [VOICE_W-1:0]  rank [NUM_VOICES];

  scan_act_e           act;
  logic                free_found;
  logic [VOICE_W-1:0]  free_v;
  logic [VOICE_W-1:0]  steal_v;
  logic [VOICE_W-1:0]  alloc_v;
  logic                hold_found;
  logic [VOICE_W-1:0]  hold_v;

  key_debouncer #(
    .WIDTH           (NUM_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .keys    (keys),
    .key_deb (key_deb)
  );

  // Flatten the per-voice key registers onto the output bus
  always_comb begin
    voice_key = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_key[v*KEY_W +: KEY_W] = vkey[v];
    end
  end

  // Decide the action for the scanned key and which voice it touches
  always_comb begin
    free_found = 1'b0;
    free_v     = '0;
    steal_v    = '0;
    hold_found = 1'b0;
    hold_v     = '0;
    // Descending walk so the lowest idle voice wins
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_gate[v]) begin
        free_found = 1'b1;
        free_v     = VOICE_W'(v);
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rank[v] == VOICE_W'(NUM_VOICES - 1)) begin
        steal_v = VOICE_W'(v);
      end
      if (voice_gate[v] && (vkey[v] == idx)) begin
        hold_found = 1'b1;
        hold_v     = VOICE_W'(v);
      end
    end
    alloc_v = free_found ? free_v : steal_v;
    if (key_deb[idx] && !served[idx]) begin
      act = ACT_ON;
    end else if (!key_deb[idx] && served[idx]) begin
      act = ACT_OFF;
    end else begin
      act = ACT_IDLE;
    end
  end

  // Allocator state machine: scan pointer, served flags, voices, ranks, events
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      served     <= '0;
      voice_gate <= '0;
      evt_valid  <= 1'b0;
      evt_on     <= EVT_OFF;
      evt_voice  <= '0;
      evt_key    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        vkey[v] <= '0;
        rank[v] <= VOICE_W'(v);
      end
    end else begin
      idx       <= idx + KEY_W'(1);
      evt_valid <= 1'b0;
      evt_on    <= EVT_OFF;
      evt_voice <= '0;
      evt_key   <= '0;
      case (act)
        ACT_ON: begin
          served[idx]         <= 1'b1;
          voice_gate[alloc_v] <= 1'b1;
          vkey[alloc_v]       <= idx;
          // Newly allocated voice becomes youngest; younger ones age by one
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (VOICE_W'(v) == alloc_v) begin
              rank[v] <= '0;
            end else if (rank[v] < rank[alloc_v]) begin
              rank[v] <= rank[v] + VOICE_W'(1);
            end
          end
          evt_valid <= 1'b1;
          evt_on    <= EVT_ON;
          evt_voice <= alloc_v;
          evt_key   <= idx;
        end
        ACT_OFF: begin
          served[idx] <= 1'b0;
          // A stolen key has no voice left, so its release is silent
          if (hold_found) begin
            voice_gate[hold_v] <= 1'b0;
            evt_valid          <= 1'b1;
            evt_on             <= EVT_OFF;
            evt_voice          <= hold_v;
            evt_key            <= idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
